// File: rtl/rx_correlator_seq_bank.sv
// rx_correlator_seq_bank
// Integrates a streamed signed sample input into chip sums, correlates each
// chip against NUM_SEQ +/-1 sequences (bits supplied per chip by a feeder),
// then scans the accumulators for the largest magnitude. Results are
// published on a one-cycle ovalid pulse and held until the next one.

module rx_correlator_seq_bank #(
  parameter  int SAMPLE_W         = 16,
  parameter  int SAMPLES_PER_CHIP = 20,
  parameter  int CHIPS_PER_SEQ    = 1023,
  parameter  int NUM_SEQ          = 16,
  parameter  int ACC_W            = 41,
  parameter  int SATURATE         = 1,
  localparam int IDX_W            = $clog2(NUM_SEQ)
) (
  input  logic                       crx_clk,
  input  logic                       rrx_rst_n,
  input  logic                       erx_en,
  input  logic                       istart,
  input  logic                       isample_valid,
  input  logic signed [SAMPLE_W-1:0] isample,
  input  logic [NUM_SEQ-1:0]         iseq_bits,
  output logic                       ochip_done,
  output logic                       obusy,
  output logic                       ovalid,
  output logic [NUM_SEQ*ACC_W-1:0]   ocorr,
  output logic [IDX_W-1:0]           opeak_idx,
  output logic [ACC_W-1:0]           opeak_abs,
  output logic                       osat
);

  // Chip sum holds SAMPLES_PER_CHIP samples without overflow.
  localparam int CS_W   = SAMPLE_W + $clog2(SAMPLES_PER_CHIP);
  // One guard bit above the wider of accumulator and chip, so a single
  // add/subtract never overflows before the clamp decision.
  localparam int EXT_W  = ((ACC_W > CS_W) ? ACC_W : CS_W) + 1;
  localparam int SCNT_W = $clog2(SAMPLES_PER_CHIP + 1);
  localparam int CCNT_W = $clog2(CHIPS_PER_SEQ + 1);
  localparam int PCNT_W = $clog2(NUM_SEQ + 1);

  localparam logic [ACC_W-1:0]        ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]        ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]        ACC_NEG = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0]        ACC_ONE = ACC_W'(1);
  localparam logic signed [EXT_W-1:0] POS_LIM = EXT_W'(ACC_MAX);
  localparam logic signed [EXT_W-1:0] NEG_LIM = -POS_LIM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_PEAK  = 2'd2
  } state_e;

  // One accumulator step: returns {clamped_flag, new_value}.
  function automatic logic [ACC_W:0] acc_step(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [CS_W-1:0]  chip,
    input logic                    plus
  );
    logic signed [EXT_W-1:0] a_x;
    logic signed [EXT_W-1:0] c_x;
    logic signed [EXT_W-1:0] sum;
    a_x = EXT_W'(acc);
    c_x = EXT_W'(chip);
    sum = plus ? (a_x + c_x) : (a_x - c_x);
    if ((SATURATE != 0) && (sum > POS_LIM)) return {1'b1, ACC_MAX};
    if ((SATURATE != 0) && (sum < NEG_LIM)) return {1'b1, ACC_NEG};
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  // Magnitude; the most negative value (only reachable when wrapping)
  // maps to the largest positive value so the result fits ACC_W bits.
  function automatic logic [ACC_W-1:0] mag(input logic [ACC_W-1:0] a);
    if (!a[ACC_W-1]) return a;
    if (a == ACC_MIN) return ACC_MAX;
    return ~a + ACC_ONE;
  endfunction

  state_e                    state_q,    state_d;
  logic [SCNT_W-1:0]         samp_cnt_q, samp_cnt_d;
  logic [CCNT_W-1:0]         chip_cnt_q, chip_cnt_d;
  logic [PCNT_W-1:0]         scan_q,     scan_d;
  logic signed [CS_W-1:0]    chip_sum_q, chip_sum_d;
  logic signed [CS_W-1:0]    chip_reg_q, chip_reg_d;
  logic                      chip_rdy_q, chip_rdy_d;
  logic signed [ACC_W-1:0]   acc_q [NUM_SEQ];
  logic signed [ACC_W-1:0]   acc_d [NUM_SEQ];
  logic                      sat_q,      sat_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic [ACC_W-1:0]          best_abs_q, best_abs_d;
  logic [NUM_SEQ*ACC_W-1:0]  ocorr_q,    ocorr_d;
  logic [IDX_W-1:0]          peak_idx_q, peak_idx_d;
  logic [ACC_W-1:0]          peak_abs_q, peak_abs_d;
  logic                      osat_q,     osat_d;
  logic                      ovalid_q,   ovalid_d;

  logic signed [CS_W-1:0]    samp_x;
  logic [ACC_W:0]            step_res [NUM_SEQ];
  logic signed [ACC_W-1:0]   scan_acc;
  logic [ACC_W-1:0]          scan_mag;
  logic                      chip_done;

  // Datapath helpers: per-sequence add/subtract result and the scanned magnitude.
  always_comb begin
    samp_x   = CS_W'(isample);
    scan_acc = '0;
    for (int k = 0; k < NUM_SEQ; k++) begin
      step_res[k] = acc_step(acc_q[k], chip_reg_q, iseq_bits[k]);
      if (scan_q == PCNT_W'(k)) scan_acc = acc_q[k];
    end
    scan_mag = mag(scan_acc);
  end

  // Next-state logic: frame FSM, sample integration, chip apply and peak scan.
  // NOTE: every variable gets its hold/default value first so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    chip_cnt_d = chip_cnt_q;
    scan_d     = scan_q;
    chip_sum_d = chip_sum_q;
    chip_reg_d = chip_reg_q;
    chip_rdy_d = 1'b0;
    sat_d      = sat_q;
    best_idx_d = best_idx_q;
    best_abs_d = best_abs_q;
    ocorr_d    = ocorr_q;
    peak_idx_d = peak_idx_q;
    peak_abs_d = peak_abs_q;
    osat_d     = osat_q;
    ovalid_d   = 1'b0;
    chip_done  = 1'b0;
    for (int k = 0; k < NUM_SEQ; k++) acc_d[k] = acc_q[k];

    unique case (state_q)
      ST_IDLE: begin
        // Waiting for istart; samples are ignored.
      end

      ST_ACCUM: begin
        // Stop accepting samples once the whole frame's chips are collected.
        if (isample_valid && (chip_cnt_q < CCNT_W'(CHIPS_PER_SEQ))) begin
          if (samp_cnt_q == SCNT_W'(SAMPLES_PER_CHIP - 1)) begin
            chip_reg_d = chip_sum_q + samp_x;
            chip_rdy_d = 1'b1;
            chip_sum_d = '0;
            samp_cnt_d = '0;
            chip_cnt_d = chip_cnt_q + CCNT_W'(1);
          end else begin
            chip_sum_d = chip_sum_q + samp_x;
            samp_cnt_d = samp_cnt_q + SCNT_W'(1);
          end
        end
        if (chip_rdy_q) begin
          chip_done = 1'b1;
          for (int k = 0; k < NUM_SEQ; k++) begin
            acc_d[k] = $signed(step_res[k][ACC_W-1:0]);
            sat_d    = sat_d | step_res[k][ACC_W];
          end
          // chip_cnt already counts the chip being applied.
          if (chip_cnt_q == CCNT_W'(CHIPS_PER_SEQ)) begin
            state_d = ST_PEAK;
            scan_d  = '0;
          end
        end
      end

      ST_PEAK: begin
        if (scan_q < PCNT_W'(NUM_SEQ)) begin
          // Strict > keeps the lowest index on ties.
          if ((scan_q == '0) || (scan_mag > best_abs_q)) begin
            best_abs_d = scan_mag;
            best_idx_d = IDX_W'(scan_q);
          end
          scan_d = scan_q + PCNT_W'(1);
        end else begin
          // Exit cycle: publish everything together with ovalid.
          for (int k = 0; k < NUM_SEQ; k++) ocorr_d[k*ACC_W +: ACC_W] = acc_q[k];
          peak_idx_d = best_idx_q;
          peak_abs_d = best_abs_q;
          osat_d     = sat_q;
          ovalid_d   = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Restart from any state; the sample of this cycle and any partial chip are dropped.
    if (istart) begin
      state_d    = ST_ACCUM;
      samp_cnt_d = '0;
      chip_cnt_d = '0;
      scan_d     = '0;
      chip_sum_d = '0;
      chip_reg_d = '0;
      chip_rdy_d = 1'b0;
      sat_d      = 1'b0;
      best_idx_d = '0;
      best_abs_d = '0;
      ovalid_d   = 1'b0;
      chip_done  = 1'b0;
      for (int k = 0; k < NUM_SEQ; k++) acc_d[k] = '0;
    end

    // Disable is a synchronous clear of all state, published outputs included.
    if (!erx_en) begin
      state_d    = ST_IDLE;
      samp_cnt_d = '0;
      chip_cnt_d = '0;
      scan_d     = '0;
      chip_sum_d = '0;
      chip_reg_d = '0;
      chip_rdy_d = 1'b0;
      sat_d      = 1'b0;
      best_idx_d = '0;
      best_abs_d = '0;
      ocorr_d    = '0;
      peak_idx_d = '0;
      peak_abs_d = '0;
      osat_d     = 1'b0;
      ovalid_d   = 1'b0;
      chip_done  = 1'b0;
      for (int k = 0; k < NUM_SEQ; k++) acc_d[k] = '0;
    end
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      chip_cnt_q <= '0;
      scan_q     <= '0;
      chip_sum_q <= '0;
      chip_reg_q <= '0;
      chip_rdy_q <= 1'b0;
      sat_q      <= 1'b0;
      best_idx_q <= '0;
      best_abs_q <= '0;
      ocorr_q    <= '0;
      peak_idx_q <= '0;
      peak_abs_q <= '0;
      osat_q     <= 1'b0;
      ovalid_q   <= 1'b0;
      // NOTE: the accumulator array is reset like any other register because
      // it must read zero after reset; bulk storage without that need is
      // normally left unreset so it can map to RAM.
      for (int k = 0; k < NUM_SEQ; k++) acc_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      chip_cnt_q <= chip_cnt_d;
      scan_q     <= scan_d;
      chip_sum_q <= chip_sum_d;
      chip_reg_q <= chip_reg_d;
      chip_rdy_q <= chip_rdy_d;
      sat_q      <= sat_d;
      best_idx_q <= best_idx_d;
      best_abs_q <= best_abs_d;
      ocorr_q    <= ocorr_d;
      peak_idx_q <= peak_idx_d;
      peak_abs_q <= peak_abs_d;
      osat_q     <= osat_d;
      ovalid_q   <= ovalid_d;
      for (int k = 0; k < NUM_SEQ; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign ochip_done = chip_done;
  assign obusy      = (state_q != ST_IDLE);
  assign ovalid     = ovalid_q;
  assign ocorr      = ocorr_q;
  assign opeak_idx  = peak_idx_q;
  assign opeak_abs  = peak_abs_q;
  assign osat       = osat_q;

endmodule

// File: tb/tb_rx_correlator_seq_bank.sv
// Directed bench for rx_correlator_seq_bank: a 4-sequence, 2-sample/chip,
// 3-chip configuration, plus two 8-bit accumulator copies (clamping and
// wrapping) driven from the same stimulus.

module tb_rx_correlator_seq_bank;

  localparam int SW  = 8;
  localparam int SPC = 2;
  localparam int CPS = 3;
  localparam int NS  = 4;
  localparam int AW  = 16;
  localparam int AWS = 8;

  logic                 crx_clk = 1'b0;
  logic                 rrx_rst_n = 1'b0;
  logic                 erx_en = 1'b0;
  logic                 istart = 1'b0;
  logic                 isample_valid = 1'b0;
  logic signed [SW-1:0] isample = '0;
  logic [NS-1:0]        iseq_bits = '0;

  logic            m_chip_done, m_busy, m_valid, m_sat;
  logic [NS*AW-1:0] m_corr;
  logic [1:0]      m_idx;
  logic [AW-1:0]   m_abs;

  logic             s_chip_done, s_busy, s_valid, s_sat;
  logic [NS*AWS-1:0] s_corr;
  logic [1:0]       s_idx;
  logic [AWS-1:0]   s_abs;

  logic             w_chip_done, w_busy, w_valid, w_sat;
  logic [NS*AWS-1:0] w_corr;
  logic [1:0]       w_idx;
  logic [AWS-1:0]   w_abs;

  rx_correlator_seq_bank #(.SAMPLE_W(SW), .SAMPLES_PER_CHIP(SPC), .CHIPS_PER_SEQ(CPS),
    .NUM_SEQ(NS), .ACC_W(AW), .SATURATE(1)) u_main (
    .crx_clk(crx_clk), .rrx_rst_n(rrx_rst_n), .erx_en(erx_en), .istart(istart),
    .isample_valid(isample_valid), .isample(isample), .iseq_bits(iseq_bits),
    .ochip_done(m_chip_done), .obusy(m_busy), .ovalid(m_valid), .ocorr(m_corr),
    .opeak_idx(m_idx), .opeak_abs(m_abs), .osat(m_sat));

  rx_correlator_seq_bank #(.SAMPLE_W(SW), .SAMPLES_PER_CHIP(SPC), .CHIPS_PER_SEQ(CPS),
    .NUM_SEQ(NS), .ACC_W(AWS), .SATURATE(1)) u_sat (
    .crx_clk(crx_clk), .rrx_rst_n(rrx_rst_n), .erx_en(erx_en), .istart(istart),
    .isample_valid(isample_valid), .isample(isample), .iseq_bits(iseq_bits),
    .ochip_done(s_chip_done), .obusy(s_busy), .ovalid(s_valid), .ocorr(s_corr),
    .opeak_idx(s_idx), .opeak_abs(s_abs), .osat(s_sat));

  rx_correlator_seq_bank #(.SAMPLE_W(SW), .SAMPLES_PER_CHIP(SPC), .CHIPS_PER_SEQ(CPS),
    .NUM_SEQ(NS), .ACC_W(AWS), .SATURATE(0)) u_wrap (
    .crx_clk(crx_clk), .rrx_rst_n(rrx_rst_n), .erx_en(erx_en), .istart(istart),
    .isample_valid(isample_valid), .isample(isample), .iseq_bits(iseq_bits),
    .ochip_done(w_chip_done), .obusy(w_busy), .ovalid(w_valid), .ocorr(w_corr),
    .opeak_idx(w_idx), .opeak_abs(w_abs), .osat(w_sat));

  always #5 crx_clk = ~crx_clk;

  int total = 0;
  int bad   = 0;

  logic [NS-1:0] seq_tab [CPS];
  int            feed_ptr = 0;
  int            done_cnt = 0;
  int            lat;

  // One clock cycle of stimulus, driven at the falling edge; the bits feeder
  // advances whenever the DUT reports that it consumed the current chip.
  task automatic cycle(input logic v, input logic signed [SW-1:0] s, input logic st);
    @(negedge crx_clk);
    istart        = st;
    isample_valid = v;
    isample       = s;
    iseq_bits     = seq_tab[feed_ptr];
    #1;
    if (m_chip_done) begin
      done_cnt++;
      if (feed_ptr < CPS - 1) feed_ptr++;
    end
  endtask

  // Start pulse, SPC*CPS samples of value s with gap idle cycles before each,
  // then wait (bounded) for ovalid. lat = cycles after the final-sample edge.
  task automatic run_frame(input logic signed [SW-1:0] s, input int gap, output int l);
    feed_ptr = 0;
    done_cnt = 0;
    cycle(1'b0, '0, 1'b1);
    feed_ptr = 0;
    done_cnt = 0;
    for (int i = 0; i < SPC * CPS; i++) begin
      for (int g = 0; g < gap; g++) cycle(1'b0, '0, 1'b0);
      cycle(1'b1, s, 1'b0);
    end
    l = -1;
    for (int c = 1; c <= 40; c++) begin
      cycle(1'b0, '0, 1'b0);
      if (m_valid) begin
        l = c - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < CPS; i++) seq_tab[i] = 4'b0101;
    rrx_rst_n = 1'b0;
    erx_en    = 1'b1;
    repeat (3) @(negedge crx_clk);
    #1;
    total++; if (m_corr !== '0)      begin bad++; $display("FAIL rst_ocorr got %h want 0", m_corr); end
    total++; if (m_idx !== '0)       begin bad++; $display("FAIL rst_peak_idx got %0d want 0", m_idx); end
    total++; if (m_abs !== '0)       begin bad++; $display("FAIL rst_peak_abs got %0d want 0", m_abs); end
    total++; if (m_sat !== 1'b0)     begin bad++; $display("FAIL rst_osat got %b want 0", m_sat); end
    total++; if (m_busy !== 1'b0)    begin bad++; $display("FAIL rst_obusy got %b want 0", m_busy); end
    total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL rst_ovalid got %b want 0", m_valid); end
    total++; if (m_chip_done !== 1'b0) begin bad++; $display("FAIL rst_chip_done got %b want 0", m_chip_done); end
    rrx_rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0);
  endtask

  // T1: +1 samples, bits 0101 -> {-6,+6,-6,+6}, ties resolve to index 0.
  task automatic test_basic();
    for (int i = 0; i < CPS; i++) seq_tab[i] = 4'b0101;
    run_frame(8'sd1, 0, lat);
    total++; if (lat !== NS + 2) begin bad++; $display("FAIL t1_latency got %0d want %0d", lat, NS + 2); end
    total++; if (m_corr !== {16'hFFFA, 16'h0006, 16'hFFFA, 16'h0006})
      begin bad++; $display("FAIL t1_ocorr got %h want fffa0006fffa0006", m_corr); end
    total++; if (m_idx !== 2'd0)   begin bad++; $display("FAIL t1_peak_idx got %0d want 0", m_idx); end
    total++; if (m_abs !== 16'd6)  begin bad++; $display("FAIL t1_peak_abs got %0d want 6", m_abs); end
    total++; if (m_sat !== 1'b0)   begin bad++; $display("FAIL t1_osat got %b want 0", m_sat); end
    total++; if (done_cnt !== CPS) begin bad++; $display("FAIL t1_chip_done_count got %0d want %0d", done_cnt, CPS); end
    total++; if (m_busy !== 1'b0)  begin bad++; $display("FAIL t1_obusy_after got %b want 0", m_busy); end
    cycle(1'b0, '0, 1'b0);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL t1_ovalid_pulse got %b want 0", m_valid); end
    total++; if (m_corr !== {16'hFFFA, 16'h0006, 16'hFFFA, 16'h0006})
      begin bad++; $display("FAIL t1_ocorr_hold got %h want fffa0006fffa0006", m_corr); end
  endtask

  // T2: seq 3 is the only maximum -> index 3.
  task automatic test_peak();
    seq_tab[0] = 4'b1101;
    seq_tab[1] = 4'b1001;
    seq_tab[2] = 4'b1010;
    run_frame(8'sd1, 0, lat);
    total++; if (m_corr !== {16'h0006, 16'hFFFE, 16'hFFFE, 16'h0002})
      begin bad++; $display("FAIL t2_ocorr got %h want 0006fffefffe0002", m_corr); end
    total++; if (m_idx !== 2'd3)  begin bad++; $display("FAIL t2_peak_idx got %0d want 3", m_idx); end
    total++; if (m_abs !== 16'd6) begin bad++; $display("FAIL t2_peak_abs got %0d want 6", m_abs); end
  endtask

  // T3: +127 samples, bits all 1: chip = 254. 16-bit sums to 762, 8-bit
  // clamping sticks at +127, 8-bit wrapping gives -2,-4,-6.
  task automatic test_saturate();
    for (int i = 0; i < CPS; i++) seq_tab[i] = 4'b1111;
    run_frame(8'sd127, 0, lat);
    total++; if (m_corr !== {4{16'h02FA}}) begin bad++; $display("FAIL t3_main_ocorr got %h want 02fa x4", m_corr); end
    total++; if (m_abs !== 16'd762) begin bad++; $display("FAIL t3_main_abs got %0d want 762", m_abs); end
    total++; if (m_sat !== 1'b0)    begin bad++; $display("FAIL t3_main_osat got %b want 0", m_sat); end
    total++; if (s_valid !== 1'b1)  begin bad++; $display("FAIL t3_sat_ovalid got %b want 1", s_valid); end
    total++; if (s_corr !== {4{8'h7F}}) begin bad++; $display("FAIL t3_sat_ocorr got %h want 7f x4", s_corr); end
    total++; if (s_abs !== 8'd127)  begin bad++; $display("FAIL t3_sat_abs got %0d want 127", s_abs); end
    total++; if (s_idx !== 2'd0)    begin bad++; $display("FAIL t3_sat_idx got %0d want 0", s_idx); end
    total++; if (s_sat !== 1'b1)    begin bad++; $display("FAIL t3_sat_osat got %b want 1", s_sat); end
    total++; if (w_valid !== 1'b1)  begin bad++; $display("FAIL t3_wrap_ovalid got %b want 1", w_valid); end
    total++; if (w_corr !== {4{8'hFA}}) begin bad++; $display("FAIL t3_wrap_ocorr got %h want fa x4", w_corr); end
    total++; if (w_abs !== 8'd6)    begin bad++; $display("FAIL t3_wrap_abs got %0d want 6", w_abs); end
    total++; if (w_sat !== 1'b0)    begin bad++; $display("FAIL t3_wrap_osat got %b want 0", w_sat); end
  endtask

  // T4: restart after 5 samples of +9; the result must match a clean frame.
  task automatic test_restart();
    for (int i = 0; i < CPS; i++) seq_tab[i] = 4'b0101;
    feed_ptr = 0;
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'sd9, 1'b0);
    total++; if (m_busy !== 1'b1) begin bad++; $display("FAIL t4_busy_mid got %b want 1", m_busy); end
    total++; if (m_corr !== {4{16'h02FA}}) begin bad++; $display("FAIL t4_ocorr_hold_mid got %h want 02fa x4", m_corr); end
    run_frame(8'sd1, 0, lat);
    total++; if (lat !== NS + 2) begin bad++; $display("FAIL t4_latency got %0d want %0d", lat, NS + 2); end
    total++; if (m_corr !== {16'hFFFA, 16'h0006, 16'hFFFA, 16'h0006})
      begin bad++; $display("FAIL t4_ocorr got %h want fffa0006fffa0006", m_corr); end
    total++; if (done_cnt !== CPS) begin bad++; $display("FAIL t4_chip_done_count got %0d want %0d", done_cnt, CPS); end
  endtask

  // T5a: asynchronous reset during the peak scan.
  task automatic test_reset_in_peak();
    logic seen;
    feed_ptr = 0;
    cycle(1'b0, '0, 1'b1);
    feed_ptr = 0;
    for (int i = 0; i < SPC * CPS; i++) cycle(1'b1, 8'sd1, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    total++; if (m_busy !== 1'b1) begin bad++; $display("FAIL t5_busy_in_peak got %b want 1", m_busy); end
    rrx_rst_n = 1'b0;
    #1;
    total++; if (m_corr !== '0)    begin bad++; $display("FAIL t5_rst_ocorr got %h want 0", m_corr); end
    total++; if (m_abs !== '0)     begin bad++; $display("FAIL t5_rst_abs got %0d want 0", m_abs); end
    total++; if (m_busy !== 1'b0)  begin bad++; $display("FAIL t5_rst_busy got %b want 0", m_busy); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL t5_rst_ovalid got %b want 0", m_valid); end
    cycle(1'b0, '0, 1'b0);
    rrx_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 8'sd1, 1'b0);
      if (m_valid || m_busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL t5_no_ovalid_after_reset got %b want 0", seen); end
  endtask

  // T5b: one cycle of erx_en low mid-frame clears state and outputs.
  task automatic test_disable();
    logic seen;
    for (int i = 0; i < CPS; i++) seq_tab[i] = 4'b0101;
    run_frame(8'sd1, 0, lat);
    total++; if (m_corr !== {16'hFFFA, 16'h0006, 16'hFFFA, 16'h0006})
      begin bad++; $display("FAIL t5b_pre_ocorr got %h want fffa0006fffa0006", m_corr); end
    feed_ptr = 0;
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'sd1, 1'b0);
    erx_en = 1'b0;
    cycle(1'b1, 8'sd1, 1'b0);
    total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL t5b_busy got %b want 0", m_busy); end
    total++; if (m_corr !== '0)   begin bad++; $display("FAIL t5b_ocorr got %h want 0", m_corr); end
    total++; if (m_abs !== '0)    begin bad++; $display("FAIL t5b_abs got %0d want 0", m_abs); end
    erx_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 8'sd1, 1'b0);
      if (m_valid || m_busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL t5b_idle_ignores_samples got %b want 0", seen); end
  endtask

  // T6: -3 samples, back-to-back and then 1-of-3 gapped; both -> {+18,-18,+18,-18}.
  task automatic test_back_to_back();
    for (int i = 0; i < CPS; i++) seq_tab[i] = 4'b0101;
    run_frame(-8'sd3, 0, lat);
    total++; if (m_corr !== {16'h0012, 16'hFFEE, 16'h0012, 16'hFFEE})
      begin bad++; $display("FAIL t6_b2b_ocorr got %h want 0012ffee0012ffee", m_corr); end
    total++; if (m_abs !== 16'd18) begin bad++; $display("FAIL t6_b2b_abs got %0d want 18", m_abs); end
    run_frame(-8'sd3, 2, lat);
    total++; if (lat !== NS + 2) begin bad++; $display("FAIL t6_gap_latency got %0d want %0d", lat, NS + 2); end
    total++; if (m_corr !== {16'h0012, 16'hFFEE, 16'h0012, 16'hFFEE})
      begin bad++; $display("FAIL t6_gap_ocorr got %h want 0012ffee0012ffee", m_corr); end
    total++; if (m_idx !== 2'd0)   begin bad++; $display("FAIL t6_gap_idx got %0d want 0", m_idx); end
    total++; if (m_abs !== 16'd18) begin bad++; $display("FAIL t6_gap_abs got %0d want 18", m_abs); end
    total++; if (done_cnt !== CPS) begin bad++; $display("FAIL t6_gap_chip_done_count got %0d want %0d", done_cnt, CPS); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_peak();
    test_saturate();
    test_restart();
    test_reset_in_peak();
    test_disable();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
